// File: rtl/simon_pkg.sv
// Shared types and constants for the simon memory-sequence game blocks.
package simon_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADD      = 3'd1,
    SHOW_ON  = 3'd2,
    SHOW_GAP = 3'd3,
    PLAYER   = 3'd4,
    WIN      = 3'd5,
    LOSE     = 3'd6
  } state_t;

  // Galois feedback mask for taps 16,14,13,11 (right-shifting form).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 16-bit Galois LFSR; shared by game blocks needing randomness.
module simon_lfsr
  import simon_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] lfsr
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/simon_seq.sv
// Memory-sequence game engine: grows a random key sequence, replays it,
// then checks the player's entries with a per-entry idle timeout.
//
//   state    | meaning
//   IDLE     | waiting for start
//   ADD      | append one random key, apply speed-up
//   SHOW_ON  | displaying mem[idx] for on_time ticks
//   SHOW_GAP | dark gap of GAP_TICKS after each key
//   PLAYER   | collecting entries, timeout running
//   WIN      | full sequence reproduced, waiting for start
//   LOSE     | wrong key or timeout, waiting for start
module simon_seq
  import simon_pkg::*;
#(
  parameter int          NUM_KEYS      = 4,
  parameter int          MAX_LEN       = 16,
  parameter int          ON_TICKS      = 30,
  parameter int          GAP_TICKS     = 30,
  parameter int          MIN_ON_TICKS  = 8,
  parameter int          SPEEDUP       = 2,
  parameter int          TIMEOUT_TICKS = 120,
  parameter logic [15:0] SEED          = 16'hACE1,
  localparam int         KW            = clog2(NUM_KEYS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          key_valid,
  input  logic [KW-1:0] key_num,
  output logic          show_valid,
  output logic [KW-1:0] show_num,
  output logic          player_turn,
  output logic          key_ok,
  output logic [6:0]    level,
  output logic          win,
  output logic          lose
);

  localparam int          AW       = clog2(MAX_LEN);
  localparam logic [7:0]  ON_INIT  = 8'(ON_TICKS);
  localparam logic [7:0]  MIN_ON   = 8'(MIN_ON_TICKS);
  localparam logic [7:0]  SPD      = 8'(SPEEDUP);
  localparam logic [8:0]  ON_FLOOR = 9'(MIN_ON_TICKS + SPEEDUP);
  localparam logic [7:0]  GAP_LAST = 8'(GAP_TICKS - 1);
  localparam logic [7:0]  TO_LAST  = 8'(TIMEOUT_TICKS - 1);
  localparam logic [6:0]  LEN_MAX  = 7'(MAX_LEN);

  state_t        state;
  logic [5:0]    idx;
  logic [5:0]    idx_nxt;
  logic [7:0]    cnt;
  logic [7:0]    cnt_inc;
  logic [7:0]    on_time;
  logic [7:0]    sped_on;
  logic [15:0]   lfsr;
  logic [KW-1:0] rnd;
  logic          unused_lfsr;
  logic          last_entry;
  logic          key_match;
  logic [KW-1:0] mem [MAX_LEN];

  simon_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .lfsr  (lfsr)
  );

  assign rnd         = lfsr[KW-1:0];
  assign unused_lfsr = ^lfsr[15:KW];

  assign idx_nxt    = idx + 6'd1;
  assign cnt_inc    = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  // level may be 64, so compare in 7 bits rather than truncating it.
  assign last_entry = ({1'b0, idx} == level - 7'd1);
  assign key_match  = (key_num == mem[idx[AW-1:0]]);
  assign sped_on    = ({1'b0, on_time} >= ON_FLOOR) ? on_time - SPD : MIN_ON;

  // Sequence storage survives reset so only the write path is clocked.
  always_ff @(posedge clk) begin
    if (state == ADD) begin
      mem[level[AW-1:0]] <= rnd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      level       <= 7'd0;
      idx         <= 6'd0;
      cnt         <= 8'd0;
      on_time     <= 8'd0;
      show_valid  <= 1'b0;
      show_num    <= '0;
      player_turn <= 1'b0;
      key_ok      <= 1'b0;
      win         <= 1'b0;
      lose        <= 1'b0;
    end else begin
      key_ok <= 1'b0;
      unique case (state)
        IDLE, WIN, LOSE: begin
          if (start) begin
            state   <= ADD;
            level   <= 7'd0;
            idx     <= 6'd0;
            cnt     <= 8'd0;
            on_time <= ON_INIT;
            win     <= 1'b0;
            lose    <= 1'b0;
          end
        end

        ADD: begin
          level <= level + 7'd1;
          if (level != 7'd0) on_time <= sped_on;
          idx        <= 6'd0;
          cnt        <= 8'd0;
          state      <= SHOW_ON;
          show_valid <= 1'b1;
          // On the first round mem[0] is being written this very edge.
          show_num   <= (level == 7'd0) ? rnd : mem[0];
        end

        SHOW_ON: begin
          if (cnt == on_time - 8'd1) begin
            state      <= SHOW_GAP;
            cnt        <= 8'd0;
            show_valid <= 1'b0;
            show_num   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        SHOW_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= 8'd0;
            if (last_entry) begin
              idx         <= 6'd0;
              state       <= PLAYER;
              player_turn <= 1'b1;
            end else begin
              idx        <= idx_nxt;
              state      <= SHOW_ON;
              show_valid <= 1'b1;
              show_num   <= mem[idx_nxt[AW-1:0]];
            end
          end else begin
            cnt <= cnt_inc;
          end
        end

        PLAYER: begin
          // A key arriving on the timeout tick still counts.
          if (key_valid) begin
            if (key_match) begin
              key_ok <= 1'b1;
              cnt    <= 8'd0;
              if (last_entry) begin
                player_turn <= 1'b0;
                if (level == LEN_MAX) begin
                  state <= WIN;
                  win   <= 1'b1;
                end else begin
                  state <= ADD;
                end
              end else begin
                idx <= idx_nxt;
              end
            end else begin
              state       <= LOSE;
              lose        <= 1'b1;
              player_turn <= 1'b0;
            end
          end else if (cnt >= TO_LAST) begin
            state       <= LOSE;
            lose        <= 1'b1;
            player_turn <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_seq.sv
// Scoreboard bench for simon_seq: stimulus queues expected events, a
// negedge monitor turns DUT outputs into events and compares them in order.
module tb_simon_seq;
  import simon_pkg::*;

  localparam int NK = 4;
  localparam int ML = 2;
  localparam int ONT = 3;
  localparam int GAP = 2;
  localparam int MINON = 2;
  localparam int SPD = 1;
  localparam int TO = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       key_valid = 1'b0;
  logic [1:0] key_num = 2'd0;
  logic       show_valid;
  logic [1:0] show_num;
  logic       player_turn;
  logic       key_ok;
  logic [6:0] level;
  logic       win;
  logic       lose;

  always #5 clk = ~clk;

  simon_seq #(
    .NUM_KEYS      (NK),
    .MAX_LEN       (ML),
    .ON_TICKS      (ONT),
    .GAP_TICKS     (GAP),
    .MIN_ON_TICKS  (MINON),
    .SPEEDUP       (SPD),
    .TIMEOUT_TICKS (TO),
    .SEED          (16'hACE1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .key_valid   (key_valid),
    .key_num     (key_num),
    .show_valid  (show_valid),
    .show_num    (show_num),
    .player_turn (player_turn),
    .key_ok      (key_ok),
    .level       (level),
    .win         (win),
    .lose        (lose)
  );

  typedef enum int {EV_SHOW, EV_OK, EV_WIN, EV_LOSE, EV_TURN} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       val;
    int       dur;
  } ev_t;

  ev_t        sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [1:0] keys [ML];
  logic [15:0] m_lfsr;

  // Reference pseudo-random source: Galois, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= lfsr_step(m_lfsr);
  end

  function automatic void check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic void observe(input ev_kind_t k, input int v, input int d);
    ev_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL sb_unexpected: got %s val=%0d dur=%0d, expected no event", k.name(), v, d);
      return;
    end
    e = sb.pop_front();
    if (e.kind != k || e.val != v || e.dur != d) begin
      miscompares++;
      $display("FAIL sb_event: got %s val=%0d dur=%0d, expected %s val=%0d dur=%0d",
               k.name(), v, d, e.kind.name(), e.val, e.dur);
    end
  endfunction

  function automatic void push(input ev_kind_t k, input int v, input int d);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.dur  = d;
    sb.push_back(e);
  endfunction

  function automatic int on_for(input int lvl);
    int o;
    o = ONT;
    for (int l = 2; l <= lvl; l++) o = (o - SPD > MINON) ? o - SPD : MINON;
    return o;
  endfunction

  function automatic void expect_replay(input int lvl);
    for (int i = 0; i < lvl; i++) push(EV_SHOW, int'(keys[i]), on_for(lvl));
    push(EV_TURN, lvl, 0);
  endfunction

  // Monitor: converts output activity into ordered events.
  initial begin
    logic p_sv, p_turn, p_win, p_lose;
    int   dur, cur_num;
    p_sv = 1'b0; p_turn = 1'b0; p_win = 1'b0; p_lose = 1'b0;
    dur = 0; cur_num = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        p_sv = 1'b0; p_turn = 1'b0; p_win = 1'b0; p_lose = 1'b0;
        dur = 0;
      end else begin
        if (key_ok) observe(EV_OK, 0, 0);
        if (win && !p_win) observe(EV_WIN, 0, 0);
        if (lose && !p_lose) observe(EV_LOSE, 0, 0);
        if (show_valid) begin
          if (!p_sv) begin
            dur = 0;
            cur_num = int'(show_num);
          end
          dur++;
        end else if (p_sv) begin
          observe(EV_SHOW, cur_num, dur);
        end
        if (player_turn && !p_turn) observe(EV_TURN, int'(level), 0);
        p_sv = show_valid; p_turn = player_turn; p_win = win; p_lose = lose;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic press(input logic [1:0] k);
    key_valid = 1'b1;
    key_num   = k;
    tick();
    key_valid = 1'b0;
    key_num   = 2'd0;
  endtask

  task automatic wait_turn(input string name);
    int n;
    n = 0;
    while (!player_turn && n < 100) begin
      tick();
      n++;
    end
    check(name, int'(player_turn), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_show_valid"}, int'(show_valid), 0);
    check({tag, "_show_num"}, int'(show_num), 0);
    check({tag, "_player_turn"}, int'(player_turn), 0);
    check({tag, "_key_ok"}, int'(key_ok), 0);
    check({tag, "_level"}, int'(level), 0);
    check({tag, "_win"}, int'(win), 0);
    check({tag, "_lose"}, int'(lose), 0);
    check({tag, "_state"}, int'(dut.state), int'(IDLE));
  endtask

  initial begin
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");
    reset = 1'b0;
    tick();

    // Game 1: level 1, level 2 with speed-up, win.
    pulse_start();
    keys[0] = m_lfsr[1:0];
    check("add_dark", int'(show_valid), 0);
    expect_replay(1);
    tick();
    check("start_latency", int'(show_valid), 1);
    check("first_show_num", int'(show_num), int'(keys[0]));
    check("level1", int'(level), 1);
    wait_turn("turn1");
    check("turn1_level", int'(level), 1);
    push(EV_OK, 0, 0);
    press(keys[0]);
    keys[1] = m_lfsr[1:0];
    expect_replay(2);
    tick();
    check("next_latency", int'(show_valid), 1);
    check("level2", int'(level), 2);
    press(~keys[0]);
    check("replay_key_no_lose", int'(lose), 0);
    wait_turn("turn2");
    push(EV_OK, 0, 0);
    press(keys[0]);
    push(EV_OK, 0, 0);
    push(EV_WIN, 0, 0);
    press(keys[1]);
    check("win_set", int'(win), 1);
    check("win_turn_off", int'(player_turn), 0);
    press(keys[0]);
    check("win_key_no_ok", int'(key_ok), 0);
    tick();
    check("win_hold", int'(win), 1);

    // Game 2: restart from WIN, wrong first key.
    pulse_start();
    keys[0] = m_lfsr[1:0];
    check("restart_win_clear", int'(win), 0);
    expect_replay(1);
    tick();
    check("restart_level", int'(level), 1);
    check("restart_show", int'(show_valid), 1);
    wait_turn("turn_g2");
    push(EV_LOSE, 0, 0);
    press(keys[0] ^ 2'b01);
    check("wrong_lose", int'(lose), 1);
    check("wrong_no_ok", int'(key_ok), 0);
    check("wrong_turn_off", int'(player_turn), 0);
    tick();
    check("g2_drained", sb.size(), 0);

    // Game 3: idle timeout.
    pulse_start();
    keys[0] = m_lfsr[1:0];
    check("restart_lose_clear", int'(lose), 0);
    expect_replay(1);
    wait_turn("turn_g3");
    push(EV_LOSE, 0, 0);
    repeat (4) tick();
    check("timeout_early", int'(lose), 0);
    tick();
    check("timeout_lose", int'(lose), 1);
    tick();
    check("g3_drained", sb.size(), 0);

    // Game 4: correct key on the timeout tick, then reset mid-replay.
    pulse_start();
    keys[0] = m_lfsr[1:0];
    expect_replay(1);
    wait_turn("turn_g4");
    repeat (4) tick();
    push(EV_OK, 0, 0);
    press(keys[0]);
    keys[1] = m_lfsr[1:0];
    check("late_key_no_lose", int'(lose), 0);
    check("late_key_ok", int'(key_ok), 1);
    expect_replay(2);
    tick();
    check("show_before_reset", int'(show_valid), 1);
    reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();

    // Fresh game after reset.
    pulse_start();
    keys[0] = m_lfsr[1:0];
    expect_replay(1);
    wait_turn("turn_g5");
    tick();
    check("final_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected bench completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/simon_seq.md
Name: simon_seq

Overview:
- Parametrised memory-sequence game engine: each round it appends one pseudo-random key to a stored sequence, replays the sequence, then checks the player's entries against it.
- Generalises the game to any power-of-2 key count, configurable maximum length, display timing and player timeout. Adds per-level speed-up, explicit win/lose states and restart.
- Sits between the debounced button/edge-detect logic and the LED/tone/display drivers; all timing is counted in clk ticks (60 Hz frame tick in the game build).

Parameters:
- NUM_KEYS, 4: number of keys/colours; power of 2, range 2..16.
- MAX_LEN, 16: sequence length that wins the game; range 2..64.
- ON_TICKS, 30: display on-time for each key at level 1.
- GAP_TICKS, 30: dark gap after each displayed key.
- MIN_ON_TICKS, 8: floor for the on-time after speed-up.
- SPEEDUP, 2: on-time reduction per level completed.
- TIMEOUT_TICKS, 120: idle ticks allowed per player entry before the player loses.
- SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- start  in  1  1-cycle pulse; starts or restarts the game from IDLE/WIN/LOSE
- key_valid  in  1  1-cycle pulse; the player pressed key_num
- key_num  in  KW  key index; KW = log2(NUM_KEYS)
- show_valid  out  1  high while a sequence key is displayed
- show_num  out  KW  displayed key; 0 when show_valid is low
- player_turn  out  1  high in PLAYER
- key_ok  out  1  1-cycle pulse on a correct entry
- level  out  7  current sequence length (0..MAX_LEN)
- win  out  1  high in WIN
- lose  out  1  high in LOSE

Behaviour:
- Reset (async, active-high):
  - state=IDLE; all outputs 0; index, tick counter and on-time register cleared; LFSR=SEED.
  - Sequence memory is not cleared.
  - Reset mid-game aborts immediately to IDLE.
- LFSR: 16-bit Galois, taps 16,14,13,11; advances every clk cycle in all states. The random key is lfsr[KW-1:0].
- Memory: MAX_LEN x KW registers, indexed by a 6-bit idx.
- IDLE / WIN / LOSE:
  - start -> ADD, with level=0 and on_time=ON_TICKS.
  - key_valid is ignored.
  - win/lose are held high until start is seen.
- ADD (1 cycle):
  - mem[level] <= random key; level <= level+1.
  - If level>0, on_time <= max(on_time-SPEEDUP, MIN_ON_TICKS).
  - idx=0 -> SHOW_ON.
- SHOW_ON:
  - show_valid=1, show_num=mem[idx] for exactly on_time cycles (counter 0..on_time-1), then -> SHOW_GAP.
- SHOW_GAP:
  - Outputs dark for exactly GAP_TICKS cycles.
  - Then if idx==level-1: idx=0, counter=0 -> PLAYER; else idx++ -> SHOW_ON.
- PLAYER:
  - The counter increments each cycle without key_valid.
  - key_valid with key_num==mem[idx]:
    - key_ok pulses next cycle; counter cleared.
    - If idx==level-1: go to WIN if level==MAX_LEN, else ADD.
    - Otherwise idx++.
  - key_valid with a mismatch -> LOSE.
  - counter reaches TIMEOUT_TICKS-1 with no key -> LOSE.
  - key_valid in the same cycle as the timeout: the key takes priority and is evaluated normally.
- start while in ADD/SHOW/PLAYER is ignored.
- key_valid outside PLAYER is ignored, including during replay; it does not count as an entry.
- Outputs are registered: show_valid, player_turn, win and lose change on the clock edge that enters or leaves the corresponding state.
- Latency:
  - start to first show_valid = 2 cycles (IDLE->ADD->SHOW_ON).
  - Correct final entry to the next show_valid = 2 cycles.
- Widths: all counters are 8 bits and saturate; no wrap-around is possible within the legal parameter ranges.

Decomposition:
- Package simon_pkg:
  - state enum: IDLE, ADD, SHOW_ON, SHOW_GAP, PLAYER, WIN, LOSE (3 bits);
  - LFSR tap constant;
  - function clog2 for KW.
- Sub-module simon_lfsr: 16-bit Galois LFSR with parameter SEED, inputs clk/reset, output lfsr[15:0]. It is shared with other game blocks that need randomness.
- The FSM, memory and counters stay in simon_seq.

Test Plan:
Bench parameters: NUM_KEYS=4, MAX_LEN=2, ON_TICKS=3, GAP_TICKS=2, MIN_ON_TICKS=2, SPEEDUP=1, TIMEOUT_TICKS=5.
- Reset, then start -> show_valid high 3 cycles, starting 2 cycles after start, with show_num=mem[0]; then 2 dark cycles; player_turn=1; level=1.
- Level 1: enter mem[0] -> key_ok pulse. Level-2 replay shows mem[0] and then mem[1], each with show_valid high for 2 cycles (speed-up applied).
- Correct entries at level 2 (MAX_LEN) -> win=1, player_turn=0. A further key_valid leaves win unchanged. start -> level=1 and a new replay.
- Wrong key at the first entry (mem[0] xor 1) -> lose=1 on the next cycle; no key_ok pulse.
- No key for 5 cycles in PLAYER -> lose=1. In a separate run, a correct key_valid on the 5th cycle -> no lose, key_ok=1.
- Assert reset during SHOW_ON -> all outputs 0 and state IDLE without waiting for a clock edge. key_valid during replay -> ignored, the replay continues unchanged.
